// File: rtl/axi_pkg.sv
// Shared AXI4 read-channel constants and the burst reader state encoding.
package axi_pkg;

  localparam logic [2:0] AXI_ARSIZE_4B  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RRESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } rd_state_e;

endpackage

// File: rtl/axi_burst_reader.sv
// AXI4 read master fetching TOTAL_NUM words as back-to-back INCR bursts,
// one burst outstanding, forwarding every beat straight to a BRAM writer.
module axi_burst_reader
  import axi_pkg::*;
#(
  parameter int TOTAL_NUM = 1536,
  parameter int BURST_LEN = 16
) (
  input  logic        axi_ACLK,
  input  logic        axi_ARESETN,
  input  logic        stage_start,
  input  logic [31:0] base_addr,
  output logic [31:0] axi_ARADDR,
  output logic [7:0]  axi_ARLEN,
  output logic [2:0]  axi_ARSIZE,
  output logic [1:0]  axi_ARBURST,
  output logic        axi_ARVALID,
  input  logic        axi_ARREADY,
  input  logic [31:0] axi_RDATA,
  input  logic [1:0]  axi_RRESP,
  input  logic        axi_RLAST,
  input  logic        axi_RVALID,
  output logic        axi_RREADY,
  output logic [31:0] dn_RDATA,
  output logic        dn_RLAST,
  output logic        dn_SHAKE,
  output logic        rd_done,
  output logic        rd_error
);

  localparam int NUM_BURSTS = TOTAL_NUM / BURST_LEN;
  localparam int BURST_W    = $clog2(NUM_BURSTS) + 1;
  localparam int BEAT_W     = $clog2(BURST_LEN) + 1;
  localparam logic [31:0]        BURST_BYTES = 32'(BURST_LEN * 4);
  localparam logic [BURST_W-1:0] LAST_BURST  = BURST_W'(NUM_BURSTS - 1);
  localparam logic [BEAT_W-1:0]  LAST_BEAT   = BEAT_W'(BURST_LEN - 1);

  rd_state_e          state_reg, state_next;
  logic               start_prev_reg;
  logic [31:0]        base_reg, base_next;
  logic [BURST_W-1:0] burst_cnt_reg, burst_cnt_next;
  logic [BEAT_W-1:0]  beat_cnt_reg, beat_cnt_next;
  logic               done_reg, done_next;
  logic               error_reg, error_next;
  logic               launch;

  assign launch      = stage_start && !start_prev_reg;
  assign axi_ARADDR  = base_reg + 32'(burst_cnt_reg) * BURST_BYTES;
  assign axi_ARLEN   = 8'(BURST_LEN - 1);
  assign axi_ARSIZE  = AXI_ARSIZE_4B;
  assign axi_ARBURST = AXI_BURST_INCR;
  assign dn_SHAKE    = axi_RVALID & axi_RREADY;
  assign dn_RDATA    = axi_RDATA;
  assign dn_RLAST    = axi_RLAST & dn_SHAKE;
  assign rd_done     = done_reg;
  assign rd_error    = error_reg;

  always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
    if (!axi_ARESETN) begin
      state_reg      <= ST_IDLE;
      start_prev_reg <= 1'b0;
      base_reg       <= '0;
      burst_cnt_reg  <= '0;
      beat_cnt_reg   <= '0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      start_prev_reg <= stage_start;
      base_reg       <= base_next;
      burst_cnt_reg  <= burst_cnt_next;
      beat_cnt_reg   <= beat_cnt_next;
      done_reg       <= done_next;
      error_reg      <= error_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    base_next      = base_reg;
    burst_cnt_next = burst_cnt_reg;
    beat_cnt_next  = beat_cnt_reg;
    done_next      = done_reg;
    error_next     = error_reg;
    axi_ARVALID    = 1'b0;
    axi_RREADY     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (launch) begin
          state_next     = ST_ADDR;
          base_next      = base_addr;
          burst_cnt_next = '0;
          beat_cnt_next  = '0;
          done_next      = 1'b0;
          error_next     = 1'b0;
        end
      end
      // A dropped stage_start is ignored here: the address must complete.
      ST_ADDR: begin
        axi_ARVALID = 1'b1;
        if (axi_ARREADY) state_next = ST_DATA;
      end
      ST_DATA: begin
        axi_RREADY = 1'b1;
        if (axi_RVALID) begin
          if (axi_RRESP != AXI_RRESP_OKAY) error_next = 1'b1;
          if ((axi_RLAST && beat_cnt_reg != LAST_BEAT) ||
              (!axi_RLAST && beat_cnt_reg >= LAST_BEAT))
            error_next = 1'b1;
          if (axi_RLAST) begin
            beat_cnt_next  = '0;
            burst_cnt_next = burst_cnt_reg + 1'b1;
            if (burst_cnt_reg == LAST_BURST) begin
              state_next = ST_DONE;
              done_next  = 1'b1;
            end else if (stage_start) begin
              state_next = ST_ADDR;
            end else begin
              state_next = ST_IDLE;
            end
          end else if (beat_cnt_reg != '1) begin
            // Saturate so an overlong burst from the slave cannot wrap.
            beat_cnt_next = beat_cnt_reg + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (!stage_start) begin
          state_next = ST_IDLE;
          done_next  = 1'b0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_burst_reader.sv
// Scoreboard bench: AXI slave model with memory, expected-beat and expected-AR queues.
module tb_axi_burst_reader;
  import axi_pkg::*;

  localparam int TOTAL_NUM = 1536;
  localparam int BURST_LEN = 16;
  localparam int NB        = TOTAL_NUM / BURST_LEN;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stage_start;
  logic [31:0] base_addr;
  logic [31:0] axi_ARADDR;
  logic [7:0]  axi_ARLEN;
  logic [2:0]  axi_ARSIZE;
  logic [1:0]  axi_ARBURST;
  logic        axi_ARVALID, axi_ARREADY;
  logic [31:0] axi_RDATA;
  logic [1:0]  axi_RRESP;
  logic        axi_RLAST, axi_RVALID, axi_RREADY;
  logic [31:0] dn_RDATA;
  logic        dn_RLAST, dn_SHAKE, rd_done, rd_error;

  always #5 clk = ~clk;

  axi_burst_reader #(.TOTAL_NUM(TOTAL_NUM), .BURST_LEN(BURST_LEN)) dut (
    .axi_ACLK(clk), .axi_ARESETN(rst_n), .stage_start(stage_start), .base_addr(base_addr),
    .axi_ARADDR(axi_ARADDR), .axi_ARLEN(axi_ARLEN), .axi_ARSIZE(axi_ARSIZE),
    .axi_ARBURST(axi_ARBURST), .axi_ARVALID(axi_ARVALID), .axi_ARREADY(axi_ARREADY),
    .axi_RDATA(axi_RDATA), .axi_RRESP(axi_RRESP), .axi_RLAST(axi_RLAST),
    .axi_RVALID(axi_RVALID), .axi_RREADY(axi_RREADY), .dn_RDATA(dn_RDATA),
    .dn_RLAST(dn_RLAST), .dn_SHAKE(dn_SHAKE), .rd_done(rd_done), .rd_error(rd_error)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        err;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] exp_ar_q[$];
  int          errors = 0;
  int          checks = 0;
  int          shake_cnt = 0;
  int          ar_cnt = 0;
  logic        err_exp = 1'b0;
  logic        pending_ar = 1'b0;
  logic [31:0] last_araddr = '0;
  bit          mon_en = 1'b0;

  // Slave configuration, set by the test thread between runs.
  int ar_delay = 0;
  bit rv_rand = 1'b0;
  bit err_on = 1'b0;
  int s_nbursts = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave: decide handshakes from the settled signals at negedge, update after posedge.
  initial begin : slave
    bit ar_hs, r_hs, arv;
    logic [31:0] ar_a, s_addr;
    int s_beat, s_bidx, ar_wait;
    bit s_active;
    s_addr = '0; s_beat = 0; s_bidx = 0; ar_wait = 0; s_active = 0;
    axi_ARREADY = 1'b0; axi_RVALID = 1'b0; axi_RDATA = '0; axi_RRESP = '0; axi_RLAST = 1'b0;
    forever begin
      @(negedge clk);
      ar_hs = axi_ARVALID && axi_ARREADY;
      r_hs  = axi_RVALID && axi_RREADY;
      arv   = axi_ARVALID;
      ar_a  = axi_ARADDR;
      @(posedge clk); #1;
      if (!rst_n) begin
        s_active = 0; s_beat = 0; ar_wait = 0;
        axi_ARREADY = (ar_delay == 0);
        axi_RVALID = 1'b0; axi_RLAST = 1'b0; axi_RRESP = '0;
      end else begin
        if (r_hs) begin
          s_beat++;
          if (s_beat == BURST_LEN) s_active = 0;
        end
        if (ar_hs) begin
          s_active = 1; s_addr = ar_a; s_beat = 0; ar_wait = 0;
          s_bidx = s_nbursts; s_nbursts++;
          axi_ARREADY = (ar_delay == 0);
        end else if (arv && !axi_ARREADY) begin
          ar_wait++;
          if (ar_wait >= ar_delay) axi_ARREADY = 1'b1;
        end
        if (!axi_RVALID || r_hs)
          axi_RVALID = s_active && (!rv_rand || ($urandom_range(0, 1) == 1));
        axi_RDATA = mem_word(s_addr + 32'(s_beat * 4));
        axi_RLAST = (s_beat == BURST_LEN - 1);
        axi_RRESP = (err_on && s_bidx == 3 && s_beat == 6) ? 2'b10 : 2'b00;
      end
    end
  end

  // Monitor: pops expected AR addresses and beats as the DUT presents them.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (pending_ar) check("arvalid_hold", 32'(axi_ARVALID), 32'd1);
      pending_ar = axi_ARVALID && !axi_ARREADY;
      if (axi_ARVALID) begin
        if (exp_ar_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ar: got %h expected none", axi_ARADDR);
        end else begin
          check("araddr", axi_ARADDR, exp_ar_q[0]);
          if (axi_ARREADY) begin
            check("arlen", 32'(axi_ARLEN), 32'(BURST_LEN - 1));
            check("arsize", 32'(axi_ARSIZE), 32'(3'b010));
            check("arburst", 32'(axi_ARBURST), 32'(2'b01));
            last_araddr = axi_ARADDR;
            void'(exp_ar_q.pop_front());
            ar_cnt++;
          end
        end
      end
      if (!dn_SHAKE && axi_RLAST) check("dn_rlast_idle", 32'(dn_RLAST), 32'd0);
      if (dn_SHAKE) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got %h expected none", dn_RDATA);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("dn_rdata", dn_RDATA, e.data);
          check("dn_rlast", 32'(dn_RLAST), 32'(e.last));
          check("rd_error_seq", 32'(rd_error), 32'(err_exp));
          check("rd_done_early", 32'(rd_done), 32'd0);
          if (e.err) err_exp = 1'b1;
        end
        shake_cnt++;
      end
    end
  end

  task automatic push_expect(input logic [31:0] base, input int nb, input bit inj);
    for (int b = 0; b < nb; b++) begin
      exp_ar_q.push_back(base + 32'(b * 64));
      for (int k = 0; k < BURST_LEN; k++) begin
        beat_t e;
        e.data = mem_word(base + 32'((b * BURST_LEN + k) * 4));
        e.last = (k == BURST_LEN - 1);
        e.err  = inj && b == 3 && k == 6;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic start_run(input int dly, input bit rnd, input bit inj);
    @(posedge clk); #1;
    ar_delay = dly; rv_rand = rnd; err_on = inj; s_nbursts = 0;
    axi_ARREADY = (dly == 0);
    err_exp = 1'b0; shake_cnt = 0; ar_cnt = 0;
    stage_start = 1'b1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!rd_done && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(rd_done), 32'd1);
  endtask

  task automatic wait_shakes(input int target, input int budget);
    int n;
    n = 0;
    while (shake_cnt < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("shake_reach", 32'(shake_cnt >= target), 32'd1);
  endtask

  task automatic finish_full(input string tag, input bit exp_err);
    check({tag, "_rd_error"}, 32'(rd_error), 32'(exp_err));
    check({tag, "_beats"}, 32'(shake_cnt), 32'(TOTAL_NUM));
    check({tag, "_bursts"}, 32'(ar_cnt), 32'(NB));
    check({tag, "_q_left"}, 32'(exp_q.size() + exp_ar_q.size()), 32'd0);
    stage_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_done_clr"}, 32'(rd_done), 32'd0);
    $display("run %s: beats=%0d bursts=%0d rd_error=%0d", tag, shake_cnt, ar_cnt, rd_error);
  endtask

  initial begin : test
    rst_n = 1'b0; stage_start = 1'b0; base_addr = BASE;
    repeat (3) @(negedge clk);
    check("rst_arvalid", 32'(axi_ARVALID), 32'd0);
    check("rst_rready", 32'(axi_RREADY), 32'd0);
    check("rst_done", 32'(rd_done), 32'd0);
    check("rst_error", 32'(rd_error), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Ideal slave: 96 bursts ending at 0x1000_17C0.
    push_expect(BASE, NB, 1'b0);
    start_run(0, 1'b0, 1'b0);
    wait_done("t1_done", 4000);
    check("t1_last_araddr", last_araddr, 32'h1000_17C0);
    finish_full("t1", 1'b0);

    // ARREADY held off 5 cycles per address.
    push_expect(BASE, NB, 1'b0);
    start_run(5, 1'b0, 1'b0);
    wait_done("t2_done", 5000);
    finish_full("t2", 1'b0);

    // Random RVALID gaps.
    push_expect(BASE, NB, 1'b0);
    start_run(0, 1'b1, 1'b0);
    wait_done("t3_done", 8000);
    finish_full("t3", 1'b0);

    // SLVERR on 7th beat of burst 3.
    push_expect(BASE, NB, 1'b1);
    start_run(0, 1'b0, 1'b1);
    wait_done("t4_done", 4000);
    finish_full("t4", 1'b1);

    // Abort during burst 10 beat 4: burst 10 finishes, no burst 11.
    push_expect(BASE, 11, 1'b0);
    start_run(0, 1'b0, 1'b0);
    wait_shakes(10 * BURST_LEN + 4, 1000);
    stage_start = 1'b0;
    wait_shakes(11 * BURST_LEN, 200);
    repeat (20) @(posedge clk);
    #1;
    check("t5_bursts", 32'(ar_cnt), 32'd11);
    check("t5_beats", 32'(shake_cnt), 32'(11 * BURST_LEN));
    check("t5_done", 32'(rd_done), 32'd0);
    check("t5_arvalid", 32'(axi_ARVALID), 32'd0);
    check("t5_rready", 32'(axi_RREADY), 32'd0);
    check("t5_q_left", 32'(exp_q.size() + exp_ar_q.size()), 32'd0);
    $display("run t5: beats=%0d bursts=%0d rd_done=%0d", shake_cnt, ar_cnt, rd_done);

    // Reset mid-burst, then restart from base on a fresh edge.
    push_expect(BASE, NB, 1'b0);
    start_run(0, 1'b0, 1'b0);
    wait_shakes(40, 500);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_arvalid", 32'(axi_ARVALID), 32'd0);
    check("t6_async_rready", 32'(axi_RREADY), 32'd0);
    check("t6_rst_done", 32'(rd_done), 32'd0);
    exp_q.delete();
    exp_ar_q.delete();
    stage_start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t6_no_relaunch", 32'(axi_ARVALID), 32'd0);
    push_expect(BASE, NB, 1'b0);
    start_run(0, 1'b0, 1'b0);
    wait_done("t6_done", 4000);
    finish_full("t6", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_burst_reader.md
AXI_BURST_READER -- requirements
Module: axi_burst_reader

Interface
REQ-001 Parameter TOTAL_NUM, 1536: 32-bit words fetched per stage; SHALL be a multiple of BURST_LEN.
REQ-002 Parameter BURST_LEN, 16: beats per AXI4 INCR burst; range 1..256.
REQ-003 axi_ACLK  in  1  sole clock; all logic on rising edge.
REQ-004 axi_ARESETN  in  1  reset, asynchronous, active-low.
REQ-005 stage_start  in  1  level; rising edge launches a fetch, low aborts.
REQ-006 base_addr  in  32  byte address of first word; sampled on launch.
REQ-007 axi_ARADDR  out  32  burst start address.
REQ-008 axi_ARLEN  out  8  constant BURST_LEN-1.
REQ-009 axi_ARSIZE  out  3  constant 3'b010.
REQ-010 axi_ARBURST  out  2  constant 2'b01 (INCR).
REQ-011 axi_ARVALID  out  1  address valid.
REQ-012 axi_ARREADY  in  1  slave address ready.
REQ-013 axi_RDATA  in  32  read data.
REQ-014 axi_RRESP  in  2  read response.
REQ-015 axi_RLAST  in  1  last beat of burst.
REQ-016 axi_RVALID  in  1  read data valid.
REQ-017 axi_RREADY  out  1  master data ready.
REQ-018 dn_RDATA  out  32  data to downstream BRAM writer, equal to axi_RDATA.
REQ-019 dn_RLAST  out  1  axi_RLAST qualified by dn_SHAKE.
REQ-020 dn_SHAKE  out  1  axi_RVALID & axi_RREADY, combinational.
REQ-021 rd_done  out  1  all TOTAL_NUM words received; sticky until stage_start low.
REQ-022 rd_error  out  1  sticky: nonzero RRESP or RLAST/beat-count mismatch.

Function
REQ-023 FSM states SHALL be IDLE, ADDR, DATA, DONE.
REQ-024 IDLE->ADDR on stage_start high while registered previous stage_start low; latch base_addr, clear burst/beat counters, rd_done, rd_error.
REQ-025 ADDR: axi_ARVALID=1, ARADDR = base_addr + burst_cnt*BURST_LEN*4; ARVALID and ARADDR SHALL hold until ARVALID&ARREADY, then ->DATA next cycle.
REQ-026 DATA: axi_RREADY=1; each handshake increments beat_cnt; only one burst outstanding.
REQ-027 On handshake with RLAST=1: beat_cnt reset, burst_cnt+1; if burst_cnt was TOTAL_NUM/BURST_LEN-1 ->DONE, else if stage_start high ->ADDR, else ->IDLE.
REQ-028 RLAST on beat other than BURST_LEN-th, or no RLAST on BURST_LEN-th beat, SHALL set rd_error; the burst ends only on RLAST handshake.
REQ-029 RRESP!=2'b00 on any handshake SHALL set rd_error; data still forwarded, fetch continues.
REQ-030 DONE: rd_done=1 from the cycle after final RLAST handshake; ->IDLE when stage_start low, clearing rd_done.
REQ-031 stage_start low in ADDR SHALL complete the pending AR handshake and its burst (AXI compliance), then ->IDLE with rd_done=0.
REQ-032 base_addr[5:0] SHALL be zero for BURST_LEN=16 so no burst crosses 4 KB; not checked in hardware.
REQ-033 burst_cnt width clog2(TOTAL_NUM/BURST_LEN)+1, beat_cnt width clog2(BURST_LEN)+1; address arithmetic modulo 2^32.

Reset
REQ-034 While axi_ARESETN low: state IDLE, ARVALID=0, RREADY=0, rd_done=0, rd_error=0, counters and latched address 0, start edge register 0.
REQ-035 Reset mid-burst SHALL drop immediately to IDLE; new fetch needs a fresh stage_start rising edge after reset release.

Structure
REQ-036 Shared package axi_pkg SHALL hold ARSIZE/ARBURST/RRESP_OKAY constants and state encoding.
REQ-037 Single flat module; no sub-module; instantiated directly upstream of the BRAM writer, dn_* wired to its axi_RDATA/axi_RLAST/axi_SHAKE.

Verification
REQ-038 TOTAL_NUM=1536, base 0x1000_0000, ARREADY/RVALID always 1 -> 96 bursts, ARADDR 0x1000_0000..0x1000_17C0 step 0x40, 1536 dn_SHAKE pulses, rd_done high, rd_error 0.
REQ-039 ARREADY delayed 5 cycles -> ARVALID/ARADDR stable all 5 cycles, no beat lost.
REQ-040 Random RVALID gaps (50%) -> dn_RDATA sequence equals memory model, 1536 words, order preserved.
REQ-041 RRESP=2'b10 on beat 7 of burst 3 -> rd_error sticky from next cycle, fetch completes, rd_done=1.
REQ-042 stage_start dropped during burst 10 beat 4 -> burst 10 completes (16 beats), no burst 11 AR, IDLE, rd_done=0.
REQ-043 axi_ARESETN asserted mid-burst -> ARVALID/RREADY 0 asynchronously; fresh rising edge restarts at base_addr.
